prf_multiport: RTL

PRF_MULTIPORT -- requirements
Module: prf_multiport

---
 rtl/prf_multiport_if.sv | 32 +++
 rtl/prf_multiport.sv | 120 ++++++++++++
 2 files changed

// File: rtl/prf_multiport_if.sv
// Bundle of the read/write/allocate signals of the multiported physical
// register file. The master side drives addresses, write data and
// control. The slave side (the register file) returns registered read
// data and ready bits.
interface prf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int NRD    = 4,
    parameter int NWR    = 2
) ();

    logic                  stall;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] dout;
    logic [NRD-1:0]        rrdy;
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_addr;

    modport master (
        output stall, raddr, we, waddr, wdata, alloc_en, alloc_addr,
        input  dout, rrdy
    );

    modport slave (
        input  stall, raddr, we, waddr, wdata, alloc_en, alloc_addr,
        output dout, rrdy
    );

endinterface

// File: rtl/prf_multiport.sv
// Multiported physical register file with a ready (scoreboard) bit per
// register. NWR write ports set ready, the rename allocate port clears it.
// NRD read ports return data and ready one cycle after the address, with
// full same-cycle bypass of writes and allocations. Register 0 can be
// hard-wired to zero/ready.
module prf_multiport #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 6,
    parameter int NRD      = 4,
    parameter int NWR      = 2,
    parameter int ZERO_R0  = 1
) (
    input  logic            clk,
    input  logic            rst,
    prf_multiport_if.slave  bus
);

    if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
        $error("prf_multiport: ADDR_W must equal log2(NUM_REGS)");
    end

    // Architectural state: data words and ready bits.
    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] ready;

    // Unpacked views of the flat port buses.
    logic [ADDR_W-1:0]   wr_addr [NWR];
    logic [DATA_W-1:0]   wr_data [NWR];
    logic [NWR-1:0]      wr_en;
    logic [ADDR_W-1:0]   rd_addr [NRD];
    logic                alloc_ok;

    // Read stage: bypassed next values for the output registers.
    logic [DATA_W-1:0]   rd_data_p0 [NRD];
    logic [NRD-1:0]      rd_rdy_p0;

    // Output registers.
    logic [NRD*DATA_W-1:0] dout_p1;
    logic [NRD-1:0]        rrdy_p1;

    // True when the address is the hard-wired zero register.
    function automatic logic is_r0(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Unpack the buses and drop writes/allocs aimed at a hard-wired r0,
    // so that neither storage nor bypass ever sees them.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wr_addr[j] = bus.waddr[j*ADDR_W +: ADDR_W];
            wr_data[j] = bus.wdata[j*DATA_W +: DATA_W];
            wr_en[j]   = bus.we[j] && !is_r0(wr_addr[j]);
        end
        for (int i = 0; i < NRD; i++) begin
            rd_addr[i] = bus.raddr[i*ADDR_W +: ADDR_W];
        end
        alloc_ok = bus.alloc_en && !is_r0(bus.alloc_addr);
    end

    // Storage update: later write ports override earlier ones on the same
    // address, and the allocate clear is applied last so it beats any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
            ready <= '1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    mem[wr_addr[j]]   <= wr_data[j];
                    ready[wr_addr[j]] <= 1'b1;
                end
            end
            if (alloc_ok) begin
                ready[bus.alloc_addr] <= 1'b0;
            end
        end
    end

    // Read stage: stored value, overridden by the winning same-cycle write,
    // then the allocate clear, then the r0 constant, mirroring storage.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data_p0[i] = mem[rd_addr[i]];
            rd_rdy_p0[i]  = ready[rd_addr[i]];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
                    rd_data_p0[i] = wr_data[j];
                    rd_rdy_p0[i]  = 1'b1;
                end
            end
            if (alloc_ok && (bus.alloc_addr == rd_addr[i])) begin
                rd_rdy_p0[i] = 1'b0;
            end
            if (is_r0(rd_addr[i])) begin
                rd_data_p0[i] = '0;
                rd_rdy_p0[i]  = 1'b1;
            end
        end
    end

    // Output registers: cleared by reset, frozen while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_p1 <= '0;
            rrdy_p1 <= '0;
        end else if (!bus.stall) begin
            for (int i = 0; i < NRD; i++) begin
                dout_p1[i*DATA_W +: DATA_W] <= rd_data_p0[i];
            end
            rrdy_p1 <= rd_rdy_p0;
        end
    end

    assign bus.dout = dout_p1;
    assign bus.rrdy = rrdy_p1;

endmodule
